inst_mem_loader: RTL and testbench

- Boot-time writer for the instruction memory, which is otherwise read-only.
- Accepts a byte stream over a valid/ready interface and assembles it into big-endian 32-bit words. The first stream byte becomes the MSB, matching the memory's byte-addressed layout.
- Issues one word write per assembled word.
- Holds the pipeline (PC and pipeline registers) frozen through cpu_hold until the image is fully written.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/adder32.sv | 15 +
 rtl/inst_mem_loader_packer.sv | 42 ++++
 rtl/inst_mem_loader.sv | 168 ++++++++++++++++
 tb/tb_inst_mem_loader.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-memory boot loader.
//   loaderState_e : states of the loader FSM
//   WORD_BYTES    : bytes per instruction word
//   HDR_BYTES     : bytes in the stream header (big-endian word count)
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loaderState_e;

  localparam int WORD_BYTES = 4;
  localparam int HDR_BYTES  = 2;

endpackage

// File: rtl/adder32.sv
// ---------------------------------------------------------------------------
// adder32
// Plain 32-bit adder, carry-out discarded.
//   i_a, i_b : operands
//   o_sum    : i_a + i_b (mod 2^32)
// ---------------------------------------------------------------------------
module adder32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/inst_mem_loader_packer.sv
// ---------------------------------------------------------------------------
// byte_to_word_packer
// Shifts accepted bytes into a 32-bit register, first byte ending up in the
// MSB, and flags the byte that completes a word.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_accept      : a byte is being accepted this cycle
//   i_byte        : the byte being accepted
//   o_wordReady   : this accept is the 4th byte of a word
//   o_word        : word including the byte accepted this cycle
// ---------------------------------------------------------------------------
module byte_to_word_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic        o_wordReady,
  output logic [31:0] o_word
);

  logic [31:0] r_shift;
  logic [1:0]  r_count;
  logic [31:0] w_nextWord;

  // The word is offered combinationally so the caller can latch the complete
  // word on the same edge that accepts its last byte.
  assign w_nextWord  = {r_shift[23:0], i_byte};
  assign o_word      = w_nextWord;
  assign o_wordReady = i_accept && (r_count == 2'd3);

  // The 2-bit count wraps naturally after the 4th byte, so each new word
  // starts at zero without an explicit clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_accept) begin
      r_shift <= w_nextWord;
      r_count <= r_count + 2'd1;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
// Boot-time writer for the instruction memory. Receives a byte stream
// (16-bit big-endian word count N, then 4*N data bytes), packs big-endian
// words and writes them from BASE_ADDR upward while holding the CPU.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_in_valid/i_in_data: byte stream, accepted when valid && ready
//   o_in_ready          : loader accepts a byte this cycle
//   i_reload            : in DONE, starts a new load
//   o_mem_write         : one-cycle word write strobe
//   o_mem_address       : byte address of the written word
//   o_mem_write_data    : written word, [31:24] = first byte received
//   o_cpu_hold          : processor must stay frozen
//   o_done              : load completed
//   o_error             : header count exceeded memory, sticky until reset
// ---------------------------------------------------------------------------
module inst_mem_loader
  import mips_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  input  logic [7:0]  i_in_data,
  output logic        o_in_ready,
  input  logic        i_reload,
  output logic        o_mem_write,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  output logic        o_cpu_hold,
  output logic        o_done,
  output logic        o_error
);

  localparam int          HDR_BITS  = HDR_BYTES * 8;
  localparam logic [31:0] MAX_WORDS = 32'((MEM_BYTES - BASE_ADDR) / WORD_BYTES);
  localparam logic [31:0] BASE      = 32'(BASE_ADDR);

  loaderState_e        r_state;
  loaderState_e        w_nextState;
  logic [7:0]          r_hdrHi;
  logic [HDR_BITS-1:0] r_wordCount;
  logic [15:0]         r_wordIdx;
  logic [31:0]         r_memAddress;
  logic [31:0]         r_memWriteData;

  logic                w_accept;
  logic                w_packAccept;
  logic                w_wordReady;
  logic [31:0]         w_packWord;
  logic [HDR_BITS-1:0] w_hdrN;
  logic [31:0]         w_addrOffset;
  logic [31:0]         w_wordAddr;

  assign w_accept     = i_in_valid && o_in_ready;
  assign w_packAccept = w_accept && (r_state == DATA);
  assign w_hdrN       = {r_hdrHi, i_in_data};
  assign w_addrOffset = {14'd0, r_wordIdx, 2'b00};

  byte_to_word_packer u_packer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_accept    (w_packAccept),
    .i_byte      (i_in_data),
    .o_wordReady (w_wordReady),
    .o_word      (w_packWord)
  );

  adder32 u_addrAdd (
    .i_a   (BASE),
    .i_b   (w_addrOffset),
    .o_sum (w_wordAddr)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= HDR_HI;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. The size check zero-extends N to 32 bits so it
  // compares cleanly against the parameter-derived word capacity.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      HDR_HI: if (w_accept) w_nextState = HDR_LO;
      HDR_LO: begin
        if (w_accept) begin
          if (w_hdrN == '0) begin
            w_nextState = DONE;
          end else if ({16'd0, w_hdrN} > MAX_WORDS) begin
            w_nextState = ERROR;
          end else begin
            w_nextState = DATA;
          end
        end
      end
      DATA:  if (w_wordReady) w_nextState = WRITE;
      WRITE: begin
        if ((r_wordIdx + 16'd1) == r_wordCount) begin
          w_nextState = DONE;
        end else begin
          w_nextState = DATA;
        end
      end
      DONE:    if (i_reload) w_nextState = HDR_HI;
      ERROR:   w_nextState = ERROR;
      default: w_nextState = HDR_HI;
    endcase
  end

  // Outputs are decoded from the state register only, so they switch on the
  // edge that enters or leaves each state.
  always_comb begin
    o_in_ready  = 1'b0;
    o_mem_write = 1'b0;
    o_cpu_hold  = 1'b1;
    o_done      = 1'b0;
    o_error     = 1'b0;
    case (r_state)
      HDR_HI, HDR_LO, DATA: o_in_ready = 1'b1;
      WRITE: o_mem_write = 1'b1;
      DONE: begin
        o_done     = 1'b1;
        o_cpu_hold = 1'b0;
      end
      ERROR:   o_error = 1'b1;
      default: o_in_ready = 1'b0;
    endcase
  end

  // Header capture, word index and the write-port registers. Address and data
  // are latched on the edge that completes a word so they are valid for the
  // whole WRITE cycle and then hold until the next word completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hdrHi        <= '0;
      r_wordCount    <= '0;
      r_wordIdx      <= '0;
      r_memAddress   <= BASE;
      r_memWriteData <= '0;
    end else begin
      if ((r_state == HDR_HI) && w_accept) begin
        r_hdrHi <= i_in_data;
      end
      if ((r_state == HDR_LO) && w_accept) begin
        r_wordCount <= w_hdrN;
        r_wordIdx   <= '0;
      end
      if (r_state == WRITE) begin
        r_wordIdx <= r_wordIdx + 16'd1;
      end
      if (w_wordReady) begin
        r_memAddress   <= w_wordAddr;
        r_memWriteData <= w_packWord;
      end
    end
  end

  assign o_mem_address    = r_memAddress;
  assign o_mem_write_data = r_memWriteData;

endmodule

// File: tb/tb_inst_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loader
// Random-stimulus bench for inst_mem_loader with a scoreboard of expected
// memory writes built from the stream format rules.
// ---------------------------------------------------------------------------
module tb_inst_mem_loader;

  localparam int MEM_BYTES = 1024;
  localparam int BASE_ADDR = 16;
  localparam int MAX_WORDS = (MEM_BYTES - BASE_ADDR) / 4;

  typedef logic [7:0] byteQ_t [$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } expWrite_t;

  logic        i_clk;
  logic        i_rst;
  logic        i_in_valid;
  logic [7:0]  i_in_data;
  logic        i_reload;
  logic        o_in_ready;
  logic        o_mem_write;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_write_data;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_error;

  expWrite_t   expQ[$];
  int          assertCount    = 0;
  int          failCount      = 0;
  int          writesSeen     = 0;
  int          writesExpected = 0;
  logic        acceptedPrev   = 1'b0;

  inst_mem_loader #(
    .MEM_BYTES (MEM_BYTES),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_in_valid       (i_in_valid),
    .i_in_data        (i_in_data),
    .o_in_ready       (o_in_ready),
    .i_reload         (i_reload),
    .o_mem_write      (o_mem_write),
    .o_mem_address    (o_mem_address),
    .o_mem_write_data (o_mem_write_data),
    .o_cpu_hold       (o_cpu_hold),
    .o_done           (o_done),
    .o_error          (o_error)
  );

  // 10-unit clock period.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Safety net so the run always ends even if the design wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Remembers whether a handshake happened on the previous edge, so the
  // monitor can confirm each write comes right after a byte was taken.
  always @(posedge i_clk) acceptedPrev <= i_in_valid && o_in_ready;

  // Monitor: every write strobe is popped against the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst && o_mem_write) begin
      writesSeen++;
      checkOutput("inReadyDuringWrite", {31'd0, o_in_ready}, 32'd0);
      checkOutput("writeAfterHandshake", {31'd0, acceptedPrev}, 32'd1);
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpectedWrite: got write addr 0x%0h data 0x%0h, expected none",
                 o_mem_address, o_mem_write_data);
      end else begin
        expWrite_t e;
        e = expQ.pop_front();
        checkOutput("memAddress", o_mem_address, e.addr);
        checkOutput("memWriteData", o_mem_write_data, e.data);
      end
    end
  end

  // Reference model: reads the header, applies the size rules, and pushes
  // one expected write for every complete 4-byte group that was sent.
  task automatic modelStream(input byteQ_t bytes);
    int n;
    if (bytes.size() < 2) return;
    n = int'(bytes[0]) * 256 + int'(bytes[1]);
    if (n == 0 || n > MAX_WORDS) return;
    for (int w = 0; w < n; w++) begin
      if (2 + 4 * (w + 1) <= bytes.size()) begin
        expWrite_t e;
        e.addr = 32'(BASE_ADDR + 4 * w);
        e.data = {bytes[2+4*w], bytes[3+4*w], bytes[4+4*w], bytes[5+4*w]};
        expQ.push_back(e);
        writesExpected++;
      end
    end
  endtask

  // Builds a header for n words followed by random data bytes.
  task automatic makeStream(input int n, output byteQ_t bytes);
    bytes = {};
    bytes.push_back(8'(n >> 8));
    bytes.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) bytes.push_back(8'($urandom));
  endtask

  // Drives one byte from a negedge and returns at the negedge after it was
  // accepted. gapMode 0 = back-to-back, 1 = idle cycle first, 2 = random.
  task automatic sendByte(input logic [7:0] b, input int gapMode);
    int waitCnt;
    if (gapMode == 1 || (gapMode == 2 && $urandom_range(0, 1) == 1)) begin
      i_in_valid = 1'b0;
      i_in_data  = 8'($urandom);
      @(negedge i_clk);
    end
    i_in_valid = 1'b1;
    i_in_data  = b;
    waitCnt    = 0;
    while (!o_in_ready && waitCnt < 50) begin
      @(negedge i_clk);
      waitCnt++;
    end
    if (!o_in_ready) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL byteAcceptTimeout: got in_ready 0 for %0d cycles, expected 1", waitCnt);
    end else begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
    i_in_valid = 1'b0;
  endtask

  // Scores a stream against the model and then drives it into the loader.
  task automatic applyStimulus(input byteQ_t bytes, input int gapMode);
    modelStream(bytes);
    foreach (bytes[i]) sendByte(bytes[i], gapMode);
  endtask

  // Checks the status outputs once the loader has settled.
  task automatic checkStatus(input string tag, input logic expDone, input logic expErr);
    repeat (2) @(negedge i_clk);
    checkOutput({tag, ".done"}, {31'd0, o_done}, {31'd0, expDone});
    checkOutput({tag, ".error"}, {31'd0, o_error}, {31'd0, expErr});
    checkOutput({tag, ".cpuHold"}, {31'd0, o_cpu_hold}, {31'd0, !expDone});
    checkOutput({tag, ".inReady"}, {31'd0, o_in_ready}, 32'd0);
    checkOutput({tag, ".pending"}, 32'(expQ.size()), 32'd0);
  endtask

  // Pulses reload for one cycle; the hold must return straight away.
  task automatic reloadPulse();
    i_reload = 1'b1;
    @(negedge i_clk);
    i_reload = 1'b0;
    checkOutput("reload.cpuHold", {31'd0, o_cpu_hold}, 32'd1);
    checkOutput("reload.done", {31'd0, o_done}, 32'd0);
    checkOutput("reload.inReady", {31'd0, o_in_ready}, 32'd1);
  endtask

  // Checks every output against its reset value.
  task automatic checkResetState(input string tag);
    checkOutput({tag, ".inReady"}, {31'd0, o_in_ready}, 32'd1);
    checkOutput({tag, ".memWrite"}, {31'd0, o_mem_write}, 32'd0);
    checkOutput({tag, ".memAddress"}, o_mem_address, 32'(BASE_ADDR));
    checkOutput({tag, ".memWriteData"}, o_mem_write_data, 32'd0);
    checkOutput({tag, ".cpuHold"}, {31'd0, o_cpu_hold}, 32'd1);
    checkOutput({tag, ".done"}, {31'd0, o_done}, 32'd0);
    checkOutput({tag, ".error"}, {31'd0, o_error}, 32'd0);
  endtask

  // Main sequence of scenarios.
  initial begin
    byteQ_t s;
    int     seenBefore;

    i_rst      = 1'b1;
    i_in_valid = 1'b0;
    i_in_data  = 8'h00;
    i_reload   = 1'b0;
    repeat (2) @(negedge i_clk);
    checkResetState("reset");
    i_rst = 1'b0;
    @(negedge i_clk);

    $display("[TB] single word load");
    s = '{8'h00, 8'h01, 8'h8C, 8'h02, 8'h00, 8'h00};
    applyStimulus(s, 0);
    checkStatus("single", 1'b1, 1'b0);
    checkOutput("single.addrHeld", o_mem_address, 32'(BASE_ADDR));
    checkOutput("single.dataHeld", o_mem_write_data, 32'h8C020000);

    $display("[TB] three words with toggling valid");
    reloadPulse();
    makeStream(3, s);
    applyStimulus(s, 1);
    checkStatus("three", 1'b1, 1'b0);

    $display("[TB] empty image");
    reloadPulse();
    seenBefore = writesSeen;
    s = '{8'h00, 8'h00};
    applyStimulus(s, 0);
    checkStatus("empty", 1'b1, 1'b0);
    checkOutput("empty.noWrites", 32'(writesSeen), 32'(seenBefore));

    $display("[TB] random images");
    for (int k = 0; k < 4; k++) begin
      reloadPulse();
      makeStream($urandom_range(1, 6), s);
      applyStimulus(s, 2);
      checkStatus("random", 1'b1, 1'b0);
    end

    $display("[TB] image filling memory exactly");
    reloadPulse();
    makeStream(MAX_WORDS, s);
    applyStimulus(s, 0);
    checkStatus("full", 1'b1, 1'b0);
    checkOutput("full.lastAddr", o_mem_address, 32'(MEM_BYTES - 4));

    $display("[TB] reset in the middle of a word");
    reloadPulse();
    s = '{8'h00, 8'h02, 8'h11, 8'h22};
    applyStimulus(s, 0);
    i_reload = 1'b1;
    @(negedge i_clk);
    i_reload = 1'b0;
    checkOutput("reloadIgnored.inReady", {31'd0, o_in_ready}, 32'd1);
    checkOutput("reloadIgnored.done", {31'd0, o_done}, 32'd0);
    #2 i_rst = 1'b1;
    #1 checkResetState("midReset");
    @(negedge i_clk);
    i_rst = 1'b0;
    s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(s, 0);
    checkStatus("afterReset", 1'b1, 1'b0);
    checkOutput("afterReset.data", o_mem_write_data, 32'h11223344);

    $display("[TB] oversize headers");
    reloadPulse();
    s = '{8'h00, 8'(MAX_WORDS + 1)};
    applyStimulus(s, 0);
    checkStatus("over", 1'b0, 1'b1);
    i_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_in_data = 8'($urandom);
      @(negedge i_clk);
      checkOutput("over.refused", {31'd0, o_in_ready}, 32'd0);
    end
    i_in_valid = 1'b0;
    i_reload   = 1'b1;
    @(negedge i_clk);
    i_reload = 1'b0;
    @(negedge i_clk);
    checkOutput("over.sticky", {31'd0, o_error}, 32'd1);
    checkOutput("over.hold", {31'd0, o_cpu_hold}, 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    checkResetState("errReset");
    i_rst = 1'b0;
    @(negedge i_clk);
    s = '{8'h01, 8'h01};
    applyStimulus(s, 0);
    checkStatus("over257", 1'b0, 1'b1);

    repeat (3) @(negedge i_clk);
    checkOutput("final.pending", 32'(expQ.size()), 32'd0);
    checkOutput("final.writeCount", 32'(writesSeen), 32'(writesExpected));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
